rot_set_buffer: RTL and testbench
=================================

Name: rot_set_buffer

Overview:
- Per-set pixel buffer on the datapath beside the set address generator.
- Captures one 8x8 RGB888 pixel set, 48 x 32-bit words, from the AHB read phase.
- Drains the same set as 48 words, pixel-rotated by degrees/direction, for the AHB write phase.
- Sits between the AHB master read-data return and write-data source. The address generator supplies addresses; this block supplies rotated data.

Parameters:
- WORDS_PER_ROW, 6, 32-bit words per 8-pixel row (8 x 24 bits / 32).
- SET_ROWS, 8, rows and pixel columns per set; fixed square set.

Ports:
- I_RB_HCLK  in  1  clock, rising edge.
- I_RB_HRESET_N  in  1  reset; asynchronous, active-low.
- I_RB_CLEAR  in  1  synchronous abort to IDLE, priority over all else.
- I_RB_START  in  1  begin operation; sampled in IDLE only.
- I_RB_DEGREES  in  2  0=0deg, 1=90, 2=180, 3=270.
- I_RB_DIRECTION  in  1  1=clockwise, 0=counter-clockwise.
- I_RB_WDATA  in  32  read-phase pixel word.
- I_RB_WVALID  in  1  WDATA valid.
- O_RB_WREADY  out  1  buffer accepting words.
- O_RB_RDATA  out  32  rotated write-phase word.
- O_RB_RVALID  out  1  RDATA valid.
- I_RB_RREADY  in  1  consumer takes RDATA.
- O_RB_SET_DONE  out  1  one-cycle pulse after the last drain beat.

Behaviour:
- Reset: state IDLE; wr_cnt=0, rd_cnt=0.
  - O_RB_WREADY=0, O_RB_RVALID=0, O_RB_SET_DONE=0, O_RB_RDATA=0.
  - Pixel storage is not reset; its contents are don't-care until filled.
- States: IDLE, FILL, DRAIN.
  - IDLE -> FILL when I_RB_START=1.
  - FILL -> DRAIN on the 48th accepted beat.
  - DRAIN -> FILL on the 48th accepted beat. No START is needed for the next set.
  - Any state -> IDLE on I_RB_CLEAR=1 (counters zeroed, outputs 0 next cycle).
- O_RB_WREADY = (state==FILL), registered-state decode. O_RB_RVALID = (state==DRAIN).
- Write beat accepted when WVALID && WREADY.
  - Beat n (0..47) is row n/6, word n%6 of the row.
  - Row byte stream: word w holds bytes 4w..4w+3; bits[7:0] = byte 4w.
  - Pixel c (0..7) = bytes 3c..3c+2; byte 3c = pixel[7:0]; 24-bit pixel is stored unaltered.
  - WVALID while WREADY=0 is ignored.
- I_RB_DEGREES/I_RB_DIRECTION are latched on the cycle of the 48th write beat and held for the whole DRAIN. Changes during DRAIN have no effect.
- Effective clockwise angle: DIRECTION=1 uses DEGREES as given. DIRECTION=0 maps 1<->3; 0 and 2 are unchanged.
- Output pixel (r,c) sources, by effective clockwise angle:
  - 0: in(r,c)
  - 90: in(7-c,r)
  - 180: in(7-r,7-c)
  - 270: in(c,7-r)
- Drain word m (0..47) is output row m/6, word m%6, packed identically to the input.
  - O_RB_RDATA is combinational from storage, rd_cnt and the latched angle. It is valid in the same cycle RVALID is high.
  - RDATA must remain stable while RVALID=1 && RREADY=0.
- rd_cnt advances only on RVALID && RREADY. wr_cnt advances only on accepted write beats. Both wrap 47->0 at the state change.
- Latency:
  - 48th write beat at edge k -> RVALID=1 from cycle k+1.
  - 48th read beat at edge k -> WREADY=1 and SET_DONE=1 in cycle k+1. SET_DONE drops at k+2.
- FILL and DRAIN are exclusive, so simultaneous write/read acceptance cannot occur.
- Async reset mid-FILL or mid-DRAIN discards the partial set. After reset the block waits for I_RB_START.
- CLEAR and START in the same cycle in IDLE: CLEAR wins and the block stays IDLE.

Test Plan:
- Test pattern: pixel(r,c) = 8r+c in bits[7:0], upper bytes 0.
  - 0deg, drain with RREADY=1 -> first RDATA=0x01000000; 48 beats; SET_DONE pulses once; WREADY=1 the next cycle.
- Same fill, DEGREES=1, DIRECTION=1 -> first RDATA=0x30000038 (pixels 56, 48).
- DEGREES=2, either direction -> first RDATA=0x3E00003F. DEGREES=1, DIRECTION=0 -> first RDATA=0x0F000007.
- Backpressure:
  - Toggle RREADY 1-0-0-1 during DRAIN -> RDATA is held while stalled; exactly 48 accepted beats; none lost or duplicated.
  - Gap WVALID randomly during FILL -> same output as gapless.
- Change DEGREES from 0 to 2 mid-DRAIN -> output continues with the angle latched at fill end.
- Reset and abort:
  - Assert I_RB_HRESET_N low asynchronously at beat 20 of FILL -> WREADY=0 and RVALID=0 immediately; after release, no activity until START.
  - I_RB_CLEAR at drain beat 10 -> IDLE next cycle and no SET_DONE.

Source files
------------

// File: rtl/rot_set_buffer_if.sv
// -----------------------------------------------------------------------------
// rot_set_buffer_if : read-phase capture / write-phase drain handshake bundle
// Revision 1.0
// -----------------------------------------------------------------------------
`default_nettype none

interface rot_set_buffer_if;
  logic        I_RB_CLEAR;
  logic        I_RB_START;
  logic [1:0]  I_RB_DEGREES;
  logic        I_RB_DIRECTION;
  logic [31:0] I_RB_WDATA;
  logic        I_RB_WVALID;
  logic        O_RB_WREADY;
  logic [31:0] O_RB_RDATA;
  logic        O_RB_RVALID;
  logic        I_RB_RREADY;
  logic        O_RB_SET_DONE;

  modport master (
    output I_RB_CLEAR, I_RB_START, I_RB_DEGREES, I_RB_DIRECTION,
    output I_RB_WDATA, I_RB_WVALID, I_RB_RREADY,
    input  O_RB_WREADY, O_RB_RDATA, O_RB_RVALID, O_RB_SET_DONE
  );

  modport slave (
    input  I_RB_CLEAR, I_RB_START, I_RB_DEGREES, I_RB_DIRECTION,
    input  I_RB_WDATA, I_RB_WVALID, I_RB_RREADY,
    output O_RB_WREADY, O_RB_RDATA, O_RB_RVALID, O_RB_SET_DONE
  );
endinterface

`default_nettype wire

// File: rtl/rot_set_buffer.sv
// -----------------------------------------------------------------------------
// rot_set_buffer : captures one 8x8 RGB888 set and drains it pixel-rotated
// Revision 1.0
// -----------------------------------------------------------------------------
`default_nettype none

module rot_set_buffer #(
  parameter int WORDS_PER_ROW = 6,
  parameter int SET_ROWS      = 8
) (
  input  logic               I_RB_HCLK,
  input  logic               I_RB_HRESET_N,
  rot_set_buffer_if.slave    bus
);

  localparam int ROW_W  = $clog2(SET_ROWS);
  localparam int WORD_W = $clog2(WORDS_PER_ROW);
  localparam int BYTE_W = WORD_W + 2;
  localparam logic [ROW_W-1:0]  LAST_ROW  = ROW_W'(SET_ROWS - 1);
  localparam logic [WORD_W-1:0] LAST_WORD = WORD_W'(WORDS_PER_ROW - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t             state;
  logic [ROW_W-1:0]   wr_row;
  logic [WORD_W-1:0]  wr_word;
  logic [ROW_W-1:0]   rd_row;
  logic [WORD_W-1:0]  rd_word;
  logic [1:0]         angle;
  logic               set_done;

  logic [23:0]        pix [SET_ROWS][SET_ROWS];

  logic               wr_fire;
  logic               rd_fire;
  logic               wr_last;
  logic               rd_last;
  logic [1:0]         eff_angle;
  logic [ROW_W-1:0]   wr_col  [4];
  logic [1:0]         wr_sub  [4];
  logic [ROW_W-1:0]   rd_col  [4];
  logic [1:0]         rd_sub  [4];
  logic [ROW_W-1:0]   src_row [4];
  logic [ROW_W-1:0]   src_col [4];
  logic [31:0]        rot_word;

  function automatic logic [BYTE_W-1:0] byte_idx(input logic [WORD_W-1:0] w, input int k);
    return {w, 2'b00} + BYTE_W'(k);
  endfunction

  assign wr_fire = bus.I_RB_WVALID && (state == FILL);
  assign rd_fire = bus.I_RB_RREADY && (state == DRAIN);
  assign wr_last = wr_fire && (wr_row == LAST_ROW) && (wr_word == LAST_WORD);
  assign rd_last = rd_fire && (rd_row == LAST_ROW) && (rd_word == LAST_WORD);

  // Counter-clockwise is the clockwise angle negated mod 4, swapping 90 and 270.
  assign eff_angle = bus.I_RB_DIRECTION ? bus.I_RB_DEGREES : (2'd0 - bus.I_RB_DEGREES);

  always_comb begin
    for (int k = 0; k < 4; k++) begin
      wr_col[k] = ROW_W'(byte_idx(wr_word, k) / BYTE_W'(3));
      wr_sub[k] = 2'(byte_idx(wr_word, k) % BYTE_W'(3));
    end
  end

  always_ff @(posedge I_RB_HCLK) begin
    if (wr_fire) begin
      for (int k = 0; k < 4; k++) begin
        pix[wr_row][wr_col[k]][{wr_sub[k], 3'b000} +: 8] <= bus.I_RB_WDATA[8*k +: 8];
      end
    end
  end

  // Each output byte maps back to a source pixel through the latched rotation.
  always_comb begin
    rot_word = '0;
    for (int k = 0; k < 4; k++) begin
      rd_col[k] = ROW_W'(byte_idx(rd_word, k) / BYTE_W'(3));
      rd_sub[k] = 2'(byte_idx(rd_word, k) % BYTE_W'(3));
      case (angle)
        2'd0: begin
          src_row[k] = rd_row;
          src_col[k] = rd_col[k];
        end
        2'd1: begin
          src_row[k] = LAST_ROW - rd_col[k];
          src_col[k] = rd_row;
        end
        2'd2: begin
          src_row[k] = LAST_ROW - rd_row;
          src_col[k] = LAST_ROW - rd_col[k];
        end
        default: begin
          src_row[k] = rd_col[k];
          src_col[k] = LAST_ROW - rd_row;
        end
      endcase
      rot_word[8*k +: 8] = pix[src_row[k]][src_col[k]][{rd_sub[k], 3'b000} +: 8];
    end
  end

  always_ff @(posedge I_RB_HCLK or negedge I_RB_HRESET_N) begin
    if (!I_RB_HRESET_N) begin
      state    <= IDLE;
      wr_row   <= '0;
      wr_word  <= '0;
      rd_row   <= '0;
      rd_word  <= '0;
      angle    <= 2'd0;
      set_done <= 1'b0;
    end else begin
      set_done <= 1'b0;
      if (bus.I_RB_CLEAR) begin
        state   <= IDLE;
        wr_row  <= '0;
        wr_word <= '0;
        rd_row  <= '0;
        rd_word <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (bus.I_RB_START) state <= FILL;
          end
          FILL: begin
            if (wr_last) begin
              wr_row  <= '0;
              wr_word <= '0;
              angle   <= eff_angle;
              state   <= DRAIN;
            end else if (wr_fire) begin
              if (wr_word == LAST_WORD) begin
                wr_word <= '0;
                wr_row  <= wr_row + 1'b1;
              end else begin
                wr_word <= wr_word + 1'b1;
              end
            end
          end
          DRAIN: begin
            if (rd_last) begin
              rd_row   <= '0;
              rd_word  <= '0;
              set_done <= 1'b1;
              state    <= FILL;
            end else if (rd_fire) begin
              if (rd_word == LAST_WORD) begin
                rd_word <= '0;
                rd_row  <= rd_row + 1'b1;
              end else begin
                rd_word <= rd_word + 1'b1;
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign bus.O_RB_WREADY   = (state == FILL);
  assign bus.O_RB_RVALID   = (state == DRAIN);
  assign bus.O_RB_RDATA    = (state == DRAIN) ? rot_word : 32'h0;
  assign bus.O_RB_SET_DONE = set_done;

endmodule

`default_nettype wire

// File: tb/tb_rot_set_buffer.sv
// -----------------------------------------------------------------------------
// tb_rot_set_buffer : table-driven set fill/drain with a rotated-word scoreboard
// Revision 1.0
// -----------------------------------------------------------------------------
`default_nettype none

module tb_rot_set_buffer;

  typedef struct {
    int          seed;
    logic [1:0]  deg;
    logic        dir;
    bit          gap;
    bit          stall;
    bit          chg;
    bit          chk_first;
    logic [31:0] first;
  } vec_t;

  logic clk;
  logic rst_n;

  rot_set_buffer_if bus ();

  rot_set_buffer #(.WORDS_PER_ROW(6), .SET_ROWS(8)) dut (
    .I_RB_HCLK     (clk),
    .I_RB_HRESET_N (rst_n),
    .bus           (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] sb [$];
  int          rd_beats = 0;
  int          done_cnt = 0;
  logic [31:0] first_seen = 32'h0;
  vec_t        vecs [9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: bound expired at %0t", name, $time);
  endtask

  function automatic logic [23:0] pix(input int seed, input int r, input int c);
    if (seed == 0) return 24'(8*r + c);
    return {8'(seed + r*5), 8'(seed ^ (c*17)), 8'(8*r + c)};
  endfunction

  function automatic logic [31:0] in_word(input int seed, input int n);
    logic [31:0] w;
    logic [23:0] p;
    int b;
    w = '0;
    for (int k = 0; k < 4; k++) begin
      b = 4*(n % 6) + k;
      p = pix(seed, n / 6, b / 3);
      w[8*k +: 8] = p[8*(b % 3) +: 8];
    end
    return w;
  endfunction

  function automatic logic [31:0] exp_word(input int seed, input logic [1:0] deg, input logic dir, input int m);
    logic [31:0] w;
    logic [23:0] p;
    int eff, r, c, b, sr, sc;
    eff = deg;
    if (!dir && deg == 2'd1) eff = 3;
    if (!dir && deg == 2'd3) eff = 1;
    r = m / 6;
    w = '0;
    for (int k = 0; k < 4; k++) begin
      b = 4*(m % 6) + k;
      c = b / 3;
      case (eff)
        0:       begin sr = r;     sc = c;     end
        1:       begin sr = 7 - c; sc = r;     end
        2:       begin sr = 7 - r; sc = 7 - c; end
        default: begin sr = c;     sc = 7 - r; end
      endcase
      p = pix(seed, sr, sc);
      w[8*k +: 8] = p[8*(b % 3) +: 8];
    end
    return w;
  endfunction

  // Monitor: every accepted drain beat is popped and compared; stalls must hold data.
  initial begin
    logic        prev_stall;
    logic [31:0] prev_data;
    prev_stall = 1'b0;
    prev_data  = 32'h0;
    forever begin
      @(negedge clk);
      if (bus.O_RB_SET_DONE) done_cnt++;
      if (prev_stall && bus.O_RB_RVALID) check("stall_hold", bus.O_RB_RDATA, prev_data);
      prev_stall = bus.O_RB_RVALID && !bus.I_RB_RREADY;
      prev_data  = bus.O_RB_RDATA;
      if (bus.O_RB_RVALID && bus.I_RB_RREADY) begin
        rd_beats++;
        if (rd_beats == 1) first_seen = bus.O_RB_RDATA;
        if (sb.size() == 0) fail_now("sb_underflow");
        else check("drain_word", bus.O_RB_RDATA, sb.pop_front());
      end
    end
  end

  task automatic write_beat(input logic [31:0] d, input bit gap, output bit ok);
    int   t;
    logic acc;
    ok = 1'b1;
    if (gap) begin
      repeat ($urandom_range(0, 2)) begin
        bus.I_RB_WVALID = 1'b0;
        bus.I_RB_WDATA  = $urandom;
        @(posedge clk); #1;
      end
    end
    bus.I_RB_WVALID = 1'b1;
    bus.I_RB_WDATA  = d;
    t = 0;
    forever begin
      @(negedge clk);
      acc = bus.O_RB_WREADY;
      @(posedge clk); #1;
      t++;
      if (acc) break;
      if (t > 200) begin
        fail_now("write_timeout");
        ok = 1'b0;
        break;
      end
    end
    bus.I_RB_WVALID = 1'b0;
  endtask

  task automatic fill_set(input int seed, input logic [1:0] deg, input logic dir, input bit gap, input int beats);
    bit ok;
    bus.I_RB_DEGREES   = deg;
    bus.I_RB_DIRECTION = dir;
    for (int n = 0; n < beats; n++) begin
      if (n == 47) begin
        for (int m = 0; m < 48; m++) sb.push_back(exp_word(seed, deg, dir, m));
      end
      write_beat(in_word(seed, n), gap, ok);
      if (!ok) return;
    end
    if (beats == 48) begin
      check("rvalid_after_fill", {31'h0, bus.O_RB_RVALID}, 32'h1);
      check("wready_after_fill", {31'h0, bus.O_RB_WREADY}, 32'h0);
    end
  endtask

  task automatic drain_set(input vec_t v);
    int t;
    int d0;
    d0 = done_cnt;
    rd_beats = 0;
    t = 0;
    while (rd_beats < 48 && t < 1000) begin
      bus.I_RB_RREADY = v.stall ? ((t % 4) == 0 || (t % 4) == 3) : 1'b1;
      if (v.stall) begin
        bus.I_RB_WVALID = 1'b1;
        bus.I_RB_WDATA  = $urandom;
      end
      if (v.chg && rd_beats >= 20) bus.I_RB_DEGREES = 2'd2;
      @(posedge clk); #1;
      t++;
    end
    bus.I_RB_RREADY = 1'b0;
    bus.I_RB_WVALID = 1'b0;
    if (t >= 1000) begin
      fail_now("drain_timeout");
      return;
    end
    check("set_done_pulse", {31'h0, bus.O_RB_SET_DONE}, 32'h1);
    check("wready_after_drain", {31'h0, bus.O_RB_WREADY}, 32'h1);
    check("rvalid_after_drain", {31'h0, bus.O_RB_RVALID}, 32'h0);
    @(posedge clk); #1;
    check("set_done_drop", {31'h0, bus.O_RB_SET_DONE}, 32'h0);
    check("beat_count", 32'(rd_beats), 32'd48);
    check("done_count", 32'(done_cnt - d0), 32'd1);
    check("sb_empty", 32'(sb.size()), 32'd0);
    if (v.chk_first) check("first_word", first_seen, v.first);
  endtask

  task automatic pulse_start();
    bus.I_RB_START = 1'b1;
    @(posedge clk); #1;
    bus.I_RB_START = 1'b0;
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    int   d0;
    int   t;
    //          seed  deg   dir   gap stall chg chk first
    vecs[0] = '{0,    2'd0, 1'b1, 0,  0,    0,  1,  32'h0100_0000};
    vecs[1] = '{0,    2'd1, 1'b1, 0,  0,    0,  1,  32'h3000_0038};
    vecs[2] = '{0,    2'd2, 1'b1, 0,  0,    0,  1,  32'h3E00_003F};
    vecs[3] = '{0,    2'd2, 1'b0, 0,  0,    0,  1,  32'h3E00_003F};
    vecs[4] = '{0,    2'd1, 1'b0, 0,  0,    0,  1,  32'h0F00_0007};
    vecs[5] = '{0,    2'd3, 1'b1, 0,  0,    0,  1,  32'h0F00_0007};
    vecs[6] = '{85,   2'd1, 1'b0, 1,  1,    0,  0,  32'h0};
    vecs[7] = '{0,    2'd0, 1'b1, 0,  0,    1,  1,  32'h0100_0000};
    vecs[8] = '{163,  2'd3, 1'b0, 1,  1,    0,  0,  32'h0};

    rst_n              = 1'b0;
    bus.I_RB_CLEAR     = 1'b0;
    bus.I_RB_START     = 1'b0;
    bus.I_RB_DEGREES   = 2'd0;
    bus.I_RB_DIRECTION = 1'b1;
    bus.I_RB_WDATA     = 32'h0;
    bus.I_RB_WVALID    = 1'b0;
    bus.I_RB_RREADY    = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    check("reset_wready",   {31'h0, bus.O_RB_WREADY},   32'h0);
    check("reset_rvalid",   {31'h0, bus.O_RB_RVALID},   32'h0);
    check("reset_set_done", {31'h0, bus.O_RB_SET_DONE}, 32'h0);
    check("reset_rdata",    bus.O_RB_RDATA,             32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("idle_wready", {31'h0, bus.O_RB_WREADY}, 32'h0);

    pulse_start();
    check("start_wready", {31'h0, bus.O_RB_WREADY}, 32'h1);

    for (int i = 0; i < 9; i++) begin
      fill_set(vecs[i].seed, vecs[i].deg, vecs[i].dir, vecs[i].gap, 48);
      drain_set(vecs[i]);
    end

    // Asynchronous reset part-way through a fill discards the partial set.
    fill_set(7, 2'd1, 1'b1, 0, 20);
    check("pre_reset_wready", {31'h0, bus.O_RB_WREADY}, 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_wready", {31'h0, bus.O_RB_WREADY}, 32'h0);
    check("async_rst_rvalid", {31'h0, bus.O_RB_RVALID}, 32'h0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    bus.I_RB_WVALID = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("post_rst_idle", {30'h0, bus.O_RB_WREADY, bus.O_RB_RVALID}, 32'h0);
    end
    bus.I_RB_WVALID = 1'b0;
    @(posedge clk); #1;
    pulse_start();
    v = '{17, 2'd2, 1'b1, 0, 0, 0, 0, 32'h0};
    fill_set(v.seed, v.deg, v.dir, v.gap, 48);
    drain_set(v);

    // CLEAR at drain beat 10 returns to IDLE with no SET_DONE.
    fill_set(60, 2'd3, 1'b1, 0, 48);
    rd_beats = 0;
    t = 0;
    bus.I_RB_RREADY = 1'b1;
    while (rd_beats < 10 && t < 200) begin
      @(posedge clk); #1;
      t++;
    end
    bus.I_RB_RREADY = 1'b0;
    if (t >= 200) fail_now("partial_drain_timeout");
    d0 = done_cnt;
    bus.I_RB_CLEAR = 1'b1;
    @(posedge clk); #1;
    bus.I_RB_CLEAR = 1'b0;
    check("clear_wready", {31'h0, bus.O_RB_WREADY}, 32'h0);
    check("clear_rvalid", {31'h0, bus.O_RB_RVALID}, 32'h0);
    check("clear_rdata",  bus.O_RB_RDATA,           32'h0);
    sb.delete();
    bus.I_RB_RREADY = 1'b1;
    repeat (50) @(posedge clk);
    #1;
    bus.I_RB_RREADY = 1'b0;
    check("clear_no_done", 32'(done_cnt - d0), 32'd0);
    check("clear_stays_idle", {30'h0, bus.O_RB_WREADY, bus.O_RB_RVALID}, 32'h0);

    // CLEAR and START together in IDLE: CLEAR wins.
    bus.I_RB_CLEAR = 1'b1;
    bus.I_RB_START = 1'b1;
    @(posedge clk); #1;
    bus.I_RB_CLEAR = 1'b0;
    bus.I_RB_START = 1'b0;
    @(posedge clk); #1;
    check("clear_beats_start", {31'h0, bus.O_RB_WREADY}, 32'h0);

    pulse_start();
    v = '{201, 2'd1, 1'b1, 1, 1, 0, 0, 32'h0};
    fill_set(v.seed, v.deg, v.dir, v.gap, 48);
    drain_set(v);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
